// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
// ----------------
// Trace capture unit that sits beside the multicycle MIPS CPU. In each cycle
// it can store the control-unit state, the PC and the IR in a circular
// buffer. It can store every cycle, or only the cycles where the state
// changes. A PC-match trigger stops capture after a configurable number of
// further samples. After capture stops, the buffer freezes and replays its
// entries oldest-first.
//
// Ports
//   clk, reset      single rising-edge clock, synchronous active-high reset
//   arm             one-cycle pulse that starts or restarts capture
//   stop            forces the end of capture
//   mode            0 = sample every cycle, 1 = sample only on state change
//   trig_en/trig_pc PC-match trigger enable and address
//   cpu_state/pc/ir observed CPU signals
//   rd_req          pop one entry (honoured only once capture is done)
//   rd_valid        rd_data holds a popped entry this cycle
//   rd_data         {ts, state, pc, ir}
//   rd_empty        no unread entries
//   armed, triggered, done, count   status outputs

module cpu_trace_buffer #(
    parameter int STATE_WIDTH = 5,
    parameter int PC_WIDTH    = 32,
    parameter int IR_WIDTH    = 32,
    parameter int TS_WIDTH    = 16,
    parameter int DEPTH       = 64,
    parameter int POST_TRIG   = 16
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         arm,
    input  logic                                         stop,
    input  logic                                         mode,
    input  logic                                         trig_en,
    input  logic [PC_WIDTH-1:0]                          trig_pc,
    input  logic [STATE_WIDTH-1:0]                       cpu_state,
    input  logic [PC_WIDTH-1:0]                          cpu_pc,
    input  logic [IR_WIDTH-1:0]                          cpu_ir,
    input  logic                                         rd_req,
    output logic                                         rd_valid,
    output logic [TS_WIDTH+STATE_WIDTH+PC_WIDTH+IR_WIDTH-1:0] rd_data,
    output logic                                         rd_empty,
    output logic                                         armed,
    output logic                                         triggered,
    output logic                                         done,
    output logic [$clog2(DEPTH):0]                       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_WIDTH + STATE_WIDTH + PC_WIDTH + IR_WIDTH;
    localparam logic [AW:0]         FULL   = (AW+1)'(DEPTH);
    localparam logic [TS_WIDTH-1:0] TS_MAX = '1;

    typedef enum logic [1:0] {IDLE, CAPTURE, POST, DONE} state_t;

    state_t                 state;
    logic [EW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr, post_cnt;
    logic [AW:0]            unread;
    logic [TS_WIDTH-1:0]    delta;
    logic [STATE_WIDTH-1:0] prev_state;
    logic                   first;

    logic                   active, qualify, store, hit, post_end, finish, go_post;
    logic [TS_WIDTH-1:0]    ts_val;
    logic [AW-1:0]          wr_ptr_nxt;
    logic [AW:0]            count_nxt;

    always_comb begin
        active     = (state == CAPTURE) || (state == POST);
        qualify    = active && (!mode || first || (cpu_state != prev_state));
        // arm wins over everything else, so an arm cycle never stores
        store      = qualify && !arm;
        hit        = (state == CAPTURE) && trig_en && (cpu_pc == trig_pc);
        ts_val     = first ? '0 : delta;
        wr_ptr_nxt = store ? wr_ptr + 1'b1 : wr_ptr;
        count_nxt  = (store && count != FULL) ? count + 1'b1 : count;
        // post_cnt is never 0 while in POST, so the store that sees 1 is the last
        post_end   = (state == POST) && store && (post_cnt == AW'(1));
        finish     = active && !arm && (stop || (hit && POST_TRIG == 0) || post_end);
        go_post    = hit && !arm && !stop && (POST_TRIG != 0);
    end

    assign armed    = active;
    assign rd_empty = (state == DONE) ? (unread == '0) : 1'b1;

    // Capture stage: the sample present in cycle N is written at edge N
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= {ts_val, cpu_state, cpu_pc, cpu_ir};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            post_cnt   <= '0;
            unread     <= '0;
            delta      <= '0;
            prev_state <= '0;
            first      <= 1'b0;
            count      <= '0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_valid   <= 1'b0;
            prev_state <= cpu_state;
            if (arm) begin
                state     <= CAPTURE;
                wr_ptr    <= '0;
                count     <= '0;
                unread    <= '0;
                post_cnt  <= '0;
                delta     <= '0;
                triggered <= 1'b0;
                done      <= 1'b0;
                first     <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr_nxt;
                count  <= count_nxt;
                if (store) begin
                    delta <= TS_WIDTH'(1);
                    first <= 1'b0;
                    if (state == POST) post_cnt <= post_cnt - 1'b1;
                end else if (active && delta != TS_MAX) begin
                    delta <= delta + 1'b1;
                end
                if (hit) triggered <= 1'b1;
                if (finish) begin
                    // A full buffer has wrapped, so its oldest entry sits at wr_ptr
                    state  <= DONE;
                    done   <= 1'b1;
                    rd_ptr <= (count_nxt == FULL) ? wr_ptr_nxt : '0;
                    unread <= count_nxt;
                end else if (go_post) begin
                    state    <= POST;
                    post_cnt <= AW'(POST_TRIG);
                end
                // Read stage: registered memory read, one entry per accepted rd_req
                if (state == DONE && rd_req && unread != '0) begin
                    rd_data  <= mem[rd_ptr];
                    rd_valid <= 1'b1;
                    rd_ptr   <= rd_ptr + 1'b1;
                    unread   <= unread - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed testbench for cpu_trace_buffer (DEPTH=8, POST_TRIG=3).
// Each scenario task drives stimulus and checks results against
// hand-computed expected values.

module tb_cpu_trace_buffer;

    localparam int SW = 5, PW = 32, IW = 32, TW = 16, DEPTH = 8, POST = 3;
    localparam int EW = TW + SW + PW + IW;

    logic          clk = 1'b0;
    logic          reset = 1'b0, arm = 1'b0, stop = 1'b0, mode = 1'b0, trig_en = 1'b0;
    logic [PW-1:0] trig_pc = '0, cpu_pc = '0;
    logic [SW-1:0] cpu_state = '0;
    logic [IW-1:0] cpu_ir = '0;
    logic          rd_req = 1'b0;
    logic          rd_valid, rd_empty, armed, triggered, done;
    logic [EW-1:0] rd_data;
    logic [3:0]    count;

    int checks = 0;
    int errors = 0;

    cpu_trace_buffer #(
        .STATE_WIDTH(SW), .PC_WIDTH(PW), .IR_WIDTH(IW), .TS_WIDTH(TW),
        .DEPTH(DEPTH), .POST_TRIG(POST)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .mode(mode),
        .trig_en(trig_en), .trig_pc(trig_pc), .cpu_state(cpu_state),
        .cpu_pc(cpu_pc), .cpu_ir(cpu_ir), .rd_req(rd_req), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_empty(rd_empty), .armed(armed),
        .triggered(triggered), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] entry(int ts, int st, int pc, int ir);
        return {TW'(ts), SW'(st), PW'(pc), IW'(ir)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({rd_valid, rd_empty, armed, triggered, done} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 01000",
                     {rd_valid, rd_empty, armed, triggered, done});
        end
        checks++;
        if (count !== 4'd0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_count_data: got count %0d data %h expected 0 0", count, rd_data);
        end
        reset = 1'b0;
        rd_req = 1'b1;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL idle_read: got valid %b empty %b expected 0 1", rd_valid, rd_empty);
        end
        rd_req = 1'b0;
    endtask

    task automatic test_linear();
        mode = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cpu_pc = PW'(4 * i); cpu_state = SW'(i); cpu_ir = 32'hA000_0000 + i;
            stop = (i == 5);
            tick();
        end
        stop = 1'b0;
        checks++;
        if (count !== 4'd6 || done !== 1'b1 || armed !== 1'b0 || rd_empty !== 1'b0) begin
            errors++;
            $display("FAIL linear_status: got count %0d done %b armed %b empty %b expected 6 1 0 0",
                     count, done, armed, rd_empty);
        end
        rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== entry(i == 0 ? 0 : 1, i, 4 * i, 32'hA000_0000 + i)) begin
                errors++;
                $display("FAIL linear_read%0d: got valid %b data %h expected 1 %h", i, rd_valid,
                         rd_data, entry(i == 0 ? 0 : 1, i, 4 * i, 32'hA000_0000 + i));
            end
        end
        checks++;
        if (rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL linear_empty: got %b expected 1", rd_empty);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_when_empty: got valid %b expected 0", rd_valid);
        end
        rd_req = 1'b0;
    endtask

    task automatic test_wrap();
        mode = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cpu_pc = PW'(4 * i); cpu_state = SW'(i); cpu_ir = 32'hB000_0000 + i;
            stop = (i == 19);
            tick();
        end
        stop = 1'b0;
        checks++;
        if (count !== 4'd8 || done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_status: got count %0d done %b expected 8 1", count, done);
        end
        rd_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== entry(1, 12 + k, 4 * (12 + k), 32'hB000_0000 + 12 + k)) begin
                errors++;
                $display("FAIL wrap_read%0d: got valid %b data %h expected 1 %h", k, rd_valid,
                         rd_data, entry(1, 12 + k, 4 * (12 + k), 32'hB000_0000 + 12 + k));
            end
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_trigger_post();
        mode = 1'b0; trig_en = 1'b1; trig_pc = 32'd40; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cpu_pc = PW'(4 * i); cpu_state = SW'(i); cpu_ir = 32'hC000_0000 + i;
            tick();
            if (i == 9 || i == 10) begin
                checks++;
                if (triggered !== (i == 10)) begin
                    errors++;
                    $display("FAIL trig_at_pc%0d: got %b expected %b", 4 * i, triggered, i == 10);
                end
            end
            if (i == 12 || i == 13) begin
                checks++;
                if (done !== (i == 13)) begin
                    errors++;
                    $display("FAIL post_done_pc%0d: got %b expected %b", 4 * i, done, i == 13);
                end
            end
        end
        trig_en = 1'b0;
        checks++;
        if (count !== 4'd8 || triggered !== 1'b1) begin
            errors++;
            $display("FAIL trig_status: got count %0d trig %b expected 8 1", count, triggered);
        end
        rd_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== entry(1, 6 + k, 4 * (6 + k), 32'hC000_0000 + 6 + k)) begin
                errors++;
                $display("FAIL trig_read%0d: got valid %b data %h expected 1 %h", k, rd_valid,
                         rd_data, entry(1, 6 + k, 4 * (6 + k), 32'hC000_0000 + 6 + k));
            end
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_state_change();
        int seq [6] = '{0, 0, 0, 1, 1, 2};
        int exp_ts [3] = '{0, 3, 2};
        int exp_st [3] = '{0, 1, 2};
        int exp_pc [3] = '{0, 12, 20};
        mode = 1'b1; cpu_state = '0; cpu_ir = 32'hD000_0000; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cpu_state = SW'(seq[i]); cpu_pc = PW'(4 * i);
            stop = (i == 5);
            tick();
        end
        stop = 1'b0;
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL sc_count: got %0d expected 3", count);
        end
        rd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== entry(exp_ts[k], exp_st[k], exp_pc[k], 32'hD000_0000)) begin
                errors++;
                $display("FAIL sc_read%0d: got valid %b data %h expected 1 %h", k, rd_valid,
                         rd_data, entry(exp_ts[k], exp_st[k], exp_pc[k], 32'hD000_0000));
            end
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_precedence();
        // arm + stop together in CAPTURE restarts capture
        mode = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        tick(); tick();
        arm = 1'b1; stop = 1'b1;
        tick();
        arm = 1'b0; stop = 1'b0;
        checks++;
        if (count !== 4'd0 || done !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL arm_over_stop: got count %0d done %b armed %b expected 0 0 1",
                     count, done, armed);
        end
        // reset while in POST
        trig_en = 1'b1; trig_pc = 32'd8; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_pc = PW'(4 * i);
            tick();
        end
        checks++;
        if (triggered !== 1'b1 || armed !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL enter_post: got trig %b armed %b done %b expected 1 1 0",
                     triggered, armed, done);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({triggered, armed, done, rd_empty, rd_valid} !== 5'b00010 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_in_post: got flags %b count %0d expected 00010 0",
                     {triggered, armed, done, rd_empty, rd_valid}, count);
        end
        // trigger and stop in the same cycle
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cpu_pc = 32'd0;
        tick();
        cpu_pc = 32'd8; stop = 1'b1;
        tick();
        stop = 1'b0; trig_en = 1'b0;
        checks++;
        if (done !== 1'b1 || triggered !== 1'b1 || count !== 4'd2 || armed !== 1'b0) begin
            errors++;
            $display("FAIL trig_and_stop: got done %b trig %b count %0d armed %b expected 1 1 2 0",
                     done, triggered, count, armed);
        end
    endtask

    task automatic test_ts_saturation();
        mode = 1'b1; cpu_state = 5'd3; cpu_pc = 32'h100; cpu_ir = 32'hE000_0000; arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        repeat (69999) @(posedge clk);
        #1;
        cpu_state = 5'd4; stop = 1'b1;
        tick();
        stop = 1'b0;
        rd_req = 1'b1;
        tick();
        checks++;
        if (rd_data !== entry(0, 3, 32'h100, 32'hE000_0000)) begin
            errors++;
            $display("FAIL sat_first: got %h expected %h", rd_data, entry(0, 3, 32'h100, 32'hE000_0000));
        end
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== entry(65535, 4, 32'h100, 32'hE000_0000)) begin
            errors++;
            $display("FAIL ts_saturation: got valid %b data %h expected 1 %h", rd_valid, rd_data,
                     entry(65535, 4, 32'h100, 32'hE000_0000));
        end
        rd_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_linear();
        test_wrap();
        test_trigger_post();
        test_state_change();
        test_precedence();
        test_ts_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
